// File: rtl/vldrdy_pkg.sv
// Shared constants, FSM state type and LFSR step function for the valid/ready traffic master.
package vldrdy_pkg;

  localparam int          DWIDTH_DEF    = 8;
  localparam int          LFSR_W        = 16;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/vldrdy_lfsr.sv
// 16-bit Fibonacci LFSR that advances while enabled; reset and load both restore the seed.
// Only the low bit is exported since that is all the throttle needs.
module vldrdy_lfsr
  import vldrdy_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic load_i,
  output logic bit_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (en_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/master_vldrdy.sv
// Incrementing-data valid/ready source with optional LFSR throttling of new beats.
// dst_val and dst_data are registered; read_counter strobes once per accepted beat.
module master_vldrdy
  import vldrdy_pkg::*;
#(
  parameter int          DWIDTH    = DWIDTH_DEF,
  parameter bit          THROTTLE  = 1'b0,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  output logic              dst_val,
  input  logic              dst_rdy,
  output logic [DWIDTH-1:0] dst_data,
  output logic              read_counter
);

  state_e            state_q;
  state_e            state_d;
  logic [DWIDTH-1:0] data_cnt_q;
  logic [DWIDTH-1:0] data_cnt_d;
  logic              lfsr_bit;
  logic              launch;
  logic              handshake;

  vldrdy_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (cfg_en),
    .load_i(1'b0),
    .bit_o (lfsr_bit)
  );

  assign launch    = cfg_en & (~THROTTLE | lfsr_bit);
  assign handshake = dst_val & dst_rdy;

  always_comb begin
    state_d    = state_q;
    data_cnt_d = data_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (handshake) begin
          data_cnt_d = data_cnt_q + 1'b1;
          state_d    = launch ? ST_VALID : ST_IDLE;
        end else if (!cfg_en) begin
          // abandon the offer; data_cnt is kept so the same value comes back later
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_cnt_q <= data_cnt_d;
    end
  end

  assign dst_val      = (state_q == ST_VALID);
  assign dst_data     = data_cnt_q;
  assign read_counter = handshake;

endmodule

// File: tb/tb_master_vldrdy.sv
// Directed plus randomized bench for master_vldrdy; two instances (unthrottled and throttled)
// share stimulus and are each tracked by a cycle-level behavioural model.
module tb_master_vldrdy;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_en;
  logic       dst_rdy;
  logic       val0, val1, rc0, rc1;
  logic [7:0] dat0, dat1;

  always #5 clk = ~clk;

  master_vldrdy #(.DWIDTH(8), .THROTTLE(1'b0), .LFSR_SEED(16'hACE1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .dst_val(val0),
    .dst_rdy(dst_rdy), .dst_data(dat0), .read_counter(rc0)
  );

  master_vldrdy #(.DWIDTH(8), .THROTTLE(1'b1), .LFSR_SEED(16'hACE1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .dst_val(val1),
    .dst_rdy(dst_rdy), .dst_data(dat1), .read_counter(rc1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: whether a beat is on offer, the next value to send, and the throttle LFSR
  logic        m_val [2];
  logic [7:0]  m_cnt [2];
  logic [15:0] m_lfsr[2];
  localparam bit THR[2] = '{1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic logic model_launch(input int k);
    return cfg_en && (!THR[k] || m_lfsr[k][0]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k]  = 1'b0;
      m_cnt[k]  = 8'd0;
      m_lfsr[k] = 16'hACE1;
    end
  endtask

  // Apply inputs mid-cycle and compare every output against the model
  task automatic drive(input logic r, input logic e, input logic d);
    @(negedge clk);
    rst_n   = r;
    cfg_en  = e;
    dst_rdy = d;
    #1;
    chk("m0_val", {31'd0, val0}, {31'd0, m_val[0]});
    chk("m0_dat", {24'd0, dat0}, {24'd0, m_cnt[0]});
    chk("m0_rc",  {31'd0, rc0},  {31'd0, m_val[0] & d});
    chk("m1_val", {31'd0, val1}, {31'd0, m_val[1]});
    chk("m1_dat", {24'd0, dat1}, {24'd0, m_cnt[1]});
    chk("m1_rc",  {31'd0, rc1},  {31'd0, m_val[1] & d});
  endtask

  // Advance the model by one rising edge using the sampled inputs
  task automatic tick();
    logic hs, ln;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        hs = m_val[k] & dst_rdy;
        ln = model_launch(k);
        if (hs) m_cnt[k] = m_cnt[k] + 8'd1;
        m_val[k] = ln | (m_val[k] & !hs & cfg_en);
        if (cfg_en) m_lfsr[k] = lfsr_step(m_lfsr[k]);
      end
    end
  endtask

  initial begin
    logic [7:0] prev;
    logic       have_prev;
    logic       wrap_seen;
    int         n_launch, n_beat;

    rst_n = 1'b0; cfg_en = 1'b1; dst_rdy = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // reset edge, then stall with the sink not ready
    drive(1'b0, 1'b1, 1'b0);
    chk("rst_val", {31'd0, val0}, 32'd0);
    chk("rst_dat", {24'd0, dat0}, 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      chk("stall_val", {31'd0, val0}, (i == 0) ? 32'd0 : 32'd1);
      chk("stall_dat", {24'd0, dat0}, 32'd0);
      chk("stall_rc", {31'd0, rc0}, 32'd0);
      tick();
    end

    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      chk("stream_dat", {24'd0, dat0}, i);
      chk("stream_rc", {31'd0, rc0}, 32'd1);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0);
    chk("after_stream_val", {31'd0, val0}, 32'd1);
    chk("after_stream_dat", {24'd0, dat0}, 32'd30);
    tick();

    // reset in the middle of a live beat
    drive(1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b0);
    chk("mrst_val", {31'd0, val0}, 32'd0);
    chk("mrst_dat", {24'd0, dat0}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      chk("restart_dat", {24'd0, dat0}, i);
      tick();
    end

    // abort while offering 5, with a ready sink during the disabled cycles
    drive(1'b1, 1'b1, 1'b0);
    chk("abort_pre_dat", {24'd0, dat0}, 32'd5);
    tick();
    drive(1'b1, 1'b0, 1'b0);
    chk("abort_pre_val", {31'd0, val0}, 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1);
      chk("abort_val", {31'd0, val0}, 32'd0);
      chk("abort_rc", {31'd0, rc0}, 32'd0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0);
    chk("reoffer_val", {31'd0, val0}, 32'd1);
    chk("reoffer_dat", {24'd0, dat0}, 32'd5);
    tick();

    // long stream through the 255 -> 0 wrap
    have_prev = 1'b0;
    wrap_seen = 1'b0;
    prev      = 8'd0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      if (rc0) begin
        if (have_prev) begin
          chk("wrap_seq", {24'd0, dat0}, {24'd0, prev + 8'd1});
          if (prev == 8'd255) wrap_seen = 1'b1;
        end
        prev      = dat0;
        have_prev = 1'b1;
      end
      tick();
    end
    chk("wrap_seen", {31'd0, wrap_seen}, 32'd1);

    // throttled instance: each beat follows a launch cycle one edge earlier
    n_launch  = 0;
    n_beat    = 0;
    have_prev = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      if (i < 999 && model_launch(1)) n_launch++;
      if (i > 0 && rc1) n_beat++;
      if (rc1) begin
        if (have_prev) chk("thr_seq", {24'd0, dat1}, {24'd0, prev + 8'd1});
        prev      = dat1;
        have_prev = 1'b1;
      end
      tick();
    end
    chk("thr_count", n_beat, n_launch);

    // random traffic with occasional disables and resets
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
